// File: rtl/vx_lsu_req_arb_pkg.sv
// Shared types for the LSU request arbiter: request/response records and FSM encodings.
// The lane count is fixed here because the packed record layouts depend on it.
package vx_lsu_req_arb_pkg;

    localparam int LSU_LANES = 4;
    localparam int UUID_W    = 16;
    localparam int WID_W     = 2;
    localparam int OP_W      = 4;
    localparam int RD_W      = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    typedef struct packed {
        logic [UUID_W-1:0]          uuid;
        logic [WID_W-1:0]           wid;
        logic [LSU_LANES-1:0]       tmask;
        logic [31:0]                pc;
        logic [OP_W-1:0]            op_type;
        logic                       is_fence;
        logic [LSU_LANES-1:0][31:0] store_data;
        logic [LSU_LANES-1:0][31:0] base_addr;
        logic [31:0]                offset;
        logic [RD_W-1:0]            rd;
        logic                       wb;
        logic                       is_prefetch;
        logic                       is_matld;
    } lsu_req_t;

    typedef struct packed {
        logic [UUID_W-1:0]          uuid;
        logic [WID_W-1:0]           wid;
        logic [LSU_LANES-1:0]       tmask;
        logic [31:0]                pc;
        logic [OP_W-1:0]            op_type;
        logic                       is_fence;
        logic [LSU_LANES-1:0][31:0] store_data;
        logic [LSU_LANES-1:0][31:0] addr;
        logic [RD_W-1:0]            rd;
        logic                       wb;
        logic                       is_prefetch;
        logic                       is_matld;
    } lsu_out_t;

endpackage

// File: rtl/vx_lsu_req_arb_fifo.sv
// Small power-of-two FIFO; head is read straight from storage so data is
// visible the cycle after the push. Callers guard push with !full and pop with !empty.
module vx_lsu_req_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign data_out = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/vx_lsu_req_arb.sv
// Round-robin arbiter over LSU request sources with per-lane address generation,
// an output queue, an outstanding-request limit and fence draining.
module vx_lsu_req_arb
    import vx_lsu_req_arb_pkg::*;
#(
    parameter int NUM_REQS    = 2,
    parameter int NUM_LANES   = LSU_LANES,
    parameter int DEPTH       = 2,
    parameter int MAX_PENDING = 16,
    localparam int SRC_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int PEND_W = $clog2(MAX_PENDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  lsu_req_t [NUM_REQS-1:0]   req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output lsu_out_t                  out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    input  logic                      rsp_done,
    output logic [PEND_W-1:0]         pending,
    output logic                      fence_busy
);

    typedef struct packed {
        logic [SRC_W-1:0] src;
        lsu_out_t         data;
    } q_entry_t;

    logic [1:0]       state;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand_idx;
    int unsigned      cand;
    logic             grant_found;
    lsu_req_t         grant_req;
    lsu_out_t         grant_out;
    q_entry_t         head_entry;
    q_entry_t         fence_q;
    logic             q_empty;
    logic             q_full;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_valid;
    logic             below_limit;
    logic             dec;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand     = (32'(ptr) + k) % 32'(NUM_REQS);
            cand_idx = SRC_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant_req = req_data[grant_idx];

    // Address is resolved before queueing so the queue and fence register hold output records.
    always_comb begin
        grant_out             = '0;
        grant_out.uuid        = grant_req.uuid;
        grant_out.wid         = grant_req.wid;
        grant_out.tmask       = grant_req.tmask;
        grant_out.pc          = grant_req.pc;
        grant_out.op_type     = grant_req.op_type;
        grant_out.is_fence    = grant_req.is_fence;
        grant_out.store_data  = grant_req.store_data;
        grant_out.rd          = grant_req.rd;
        grant_out.wb          = grant_req.wb;
        grant_out.is_prefetch = grant_req.is_prefetch;
        grant_out.is_matld    = grant_req.is_matld;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            grant_out.addr[l] = grant_req.tmask[l] ? (grant_req.base_addr[l] + grant_req.offset) : '0;
        end
    end

    assign accept      = reset && (state == ST_IDLE) && !q_full && grant_found;
    assign req_ready   = accept ? (NUM_REQS'(1) << grant_idx) : '0;
    assign push        = accept && !grant_req.is_fence;
    assign below_limit = (pending < PEND_W'(MAX_PENDING));
    assign fifo_valid  = (state != ST_ISSUE) && !q_empty && below_limit;
    assign pop         = reset && fifo_valid && out_ready;
    assign dec         = rsp_done && (pending != '0);

    assign out_valid  = reset && ((state == ST_ISSUE) || fifo_valid);
    assign out_data   = (state == ST_ISSUE) ? fence_q.data : head_entry.data;
    assign out_src    = (state == ST_ISSUE) ? fence_q.src  : head_entry.src;
    assign fence_busy = reset && (state != ST_IDLE);

    vx_lsu_req_arb_fifo #(
        .WIDTH ($bits(q_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (q_entry_t'{src: grant_idx, data: grant_out}),
        .data_out (head_entry),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            pending <= '0;
            fence_q <= '0;
        end else begin
            if (accept) begin
                ptr <= (grant_idx == SRC_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && grant_req.is_fence) begin
                        fence_q <= q_entry_t'{src: grant_idx, data: grant_out};
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: if (q_empty && (pending == '0)) state <= ST_ISSUE;
                ST_ISSUE: if (out_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            case ({pop, dec})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: ;
            endcase
        end
    end

    // A completion with nothing outstanding is dropped by the counter logic above.
    rsp_without_pending: assert property (@(posedge clk) disable iff (!reset) rsp_done |-> (pending != '0));

endmodule

// File: doc/vx_lsu_req_arb.md
VX_LSU_REQ_ARB -- requirements
Module: VX_lsu_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, number of LSU request sources arbitrated.
REQ-002 SHALL have parameter NUM_LANES, default `NUM_THREADS, lanes per request.
REQ-003 SHALL have parameter DEPTH, default 2, output queue entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_PENDING, default 16, outstanding-request limit.
REQ-005 SHALL have port clk  in  1  single clock; every register updates on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous and active-low (0 = reset).
REQ-007 SHALL have port req_valid  in  NUM_REQS  per-source request valid.
REQ-008 SHALL have port req_data  in  NUM_REQS x lsu_req_t  per-source fields: uuid, wid, tmask, PC, op_type, is_fence, store_data, base_addr, offset, rd, wb, is_prefetch, is_matld.
REQ-009 SHALL have port req_ready  out  NUM_REQS  per-source accept.
REQ-010 SHALL have port out_valid  out  1  request to the memory path.
REQ-011 SHALL have port out_data  out  lsu_out_t  same fields with base_addr/offset replaced by per-lane addr.
REQ-012 SHALL have port out_src  out  clog2(NUM_REQS)  source index of out_data.
REQ-013 SHALL have port out_ready  in  1  downstream accept.
REQ-014 SHALL have port rsp_done  in  1  one pulse per completed non-fence request.
REQ-015 SHALL have port pending  out  clog2(MAX_PENDING+1)  outstanding count.
REQ-016 SHALL have port fence_busy  out  1  fence drain or issue in progress.

Function
REQ-017 SHALL grant round-robin: highest priority is ptr, then ptr+1, ... mod NUM_REQS; ptr resets to 0; on accept ptr becomes granted+1 mod NUM_REQS.
REQ-018 SHALL accept (req_ready[i]=1) only the granted valid source, only when queue not full and FSM in IDLE; req_ready SHALL not depend combinationally on out_ready.
REQ-019 SHALL compute addr[l] = base_addr[l] + offset, 32-bit, carry discarded (0xFFFFFFFC + 8 = 0x00000004); lanes with tmask[l]=0 SHALL carry addr 0.
REQ-020 SHALL push accepted non-fence requests into a DEPTH-entry FIFO; minimum latency req accept -> out_valid is 1 cycle; order preserved.
REQ-021 SHALL drive out_valid = FIFO not empty AND pending < MAX_PENDING in IDLE; out_data/out_src stable while out_valid && !out_ready.
REQ-022 SHALL allow push and pop in the same cycle; full is evaluated before pop (no pass-through when full).
REQ-023 SHALL increment pending on out_valid && out_ready of non-fence, decrement on rsp_done, hold if both; rsp_done at pending=0 ignored (assertion).
REQ-024 SHALL implement FSM IDLE, DRAIN, ISSUE: accepted fence is captured in a holding register and IDLE -> DRAIN; DRAIN -> ISSUE when FIFO empty and pending=0 (same cycle check); ISSUE presents the fence (out_valid=1, from holding register) and -> IDLE on out_ready.
REQ-025 SHALL not push fences into the FIFO nor count them in pending; fence_busy=1 in DRAIN and ISSUE.
REQ-026 SHALL keep popping the FIFO during DRAIN subject to REQ-021 limit.

Reset
REQ-027 SHALL, while reset=0 at a clock edge: empty FIFO, ptr=0, pending=0, FSM=IDLE; out_valid, req_ready, fence_busy SHALL be 0 during reset.
REQ-028 SHALL discard any queued, held-fence or in-flight state on reset mid-operation; no output asserted the cycle after reset deasserts.

Structure
REQ-029 SHALL place lsu_req_t, lsu_out_t and FSM state enum in the shared package VX_gpu_pkg.
REQ-030 SHALL use the existing VX_fifo_queue sub-module for the DEPTH-entry queue; arbiter, address adder and FSM stay in this module.

Verification
REQ-031 SHALL cover: both sources valid continuously, out_ready=1 -> grants alternate 0,1,0,1, out_src matches.
REQ-032 SHALL cover: base_addr=0xFFFFFFFC, offset=8, tmask=4'b0101 -> addr lanes 0,2 = 0x4, lanes 1,3 = 0.
REQ-033 SHALL cover: out_ready=0, 3 requests on source 0 with DEPTH=2 -> 2 accepted, req_ready=0 thereafter, order kept on release.
REQ-034 SHALL cover: 2 requests issued, fence arrives -> fence_busy=1, no accepts, fence out only after 2 rsp_done pulses and pending=0.
REQ-035 SHALL cover: MAX_PENDING=16 reached without rsp_done -> out_valid=0; one rsp_done -> one more issue.
REQ-036 SHALL cover: reset=0 during DRAIN with FIFO non-empty -> next cycle out_valid=0, pending=0, fence_busy=0.
